mc_control_unit: RTL
====================

Name: mc_control_unit

Overview:
- Control finite-state machine (FSM) for the multi-cycle CPU. It sequences the shared datapath (PC, instruction register (IR), register file, ALU, data memory) through fetch, decode, execute, memory and write-back states.
- Inputs: the IR opcode field and ALU flags. Outputs: every datapath write-enable and mux select.
- Instantiated inside CPU_multi_cycle, alongside the datapath.

Parameters:
- OPW, 6, opcode width.
- STW, 3, state-code width.

Ports:
- CLK  in  1  system clock; all state changes on rising edge.
- Reset  in  1  synchronous, active-high reset.
- opcode  in  OPW  IR[31:26]; stable from the end of IF until the next IF.
- zero  in  1  ALU result == 0.
- sign  in  1  ALU result[31].
- mem_ready  in  1  data-memory ready; used only with MEM_WAIT_EN.
- PCWre  out  1  PC load enable.
- IRWre  out  1  IR load enable.
- InsMemRW  out  1  instruction-memory read.
- ALUSrcA  out  1  1 = shamt, 0 = rs.
- ALUSrcB  out  1  1 = extended immediate, 0 = rt.
- ALUOp  out  3  000 add, 001 sub, 010 sll, 011 or, 100 and, 110 signed slt.
- ExtSel  out  1  1 = sign-extend, 0 = zero-extend.
- RegDst  out  2  00 = $31, 01 = rt, 10 = rd.
- RegWre  out  1  register-file write.
- WrRegDSrc  out  1  0 = PC+4, 1 = data bus (DB).
- DBDataSrc  out  1  0 = ALU, 1 = memory.
- mRD  out  1  memory read.
- mWR  out  1  memory write.
- PCSrc  out  2  00 = PC+4, 01 = branch target, 10 = rs (jr), 11 = jump target.
- state  out  STW  current state, for debug.

Behaviour:
- Opcodes:
  - add 000000, sub 000001, addi 000010
  - or 010000, and 010001, ori 010010, sll 011000
  - slt 100110, slti 100111
  - sw 110000, lw 110001
  - beq 110100, bne 110101, bltz 110110
  - j 111000, jr 111001, jal 111010, halt 111111
  - Any other opcode is a NOP.
- State codes: IF 000, ID 001, EXE_MEM 010, MEM 011, WB_LD 100, EXE_BR 101, EXE_ALU 110, WB_ALU 111.
- Reset:
  - Reset high at a rising edge: state <= IF.
  - While Reset is high, every output except state is forced to 0, so no write can occur.
- Outputs are combinational from (state, opcode, zero, sign). Signals not listed for a state are 0.
- IF: IRWre=1, InsMemRW=1. Next state ID.
- ID:
  - j / jr / jal: PCWre=1, PCSrc=11 / 10 / 11. Next state IF.
  - jal additionally: RegWre=1, RegDst=00, WrRegDSrc=0.
  - halt: all outputs 0, next state IF. The PC is not advanced, so halt re-fetches forever until Reset.
  - NOP: PCWre=1, PCSrc=00. Next state IF.
  - beq / bne / bltz: next state EXE_BR.
  - lw / sw: next state EXE_MEM.
  - Any other valid opcode: next state EXE_ALU.
- EXE_ALU:
  - ALUOp per instruction; addi / slti use add / slt.
  - ALUSrcB=1 for addi, ori, slti.
  - ALUSrcA=1 for sll.
  - ExtSel=1 except ori (0).
  - Next state WB_ALU.
- WB_ALU:
  - ALU controls held as in EXE_ALU.
  - RegWre=1, WrRegDSrc=1, DBDataSrc=0.
  - RegDst=01 for immediate-form instructions, 10 otherwise.
  - PCWre=1, PCSrc=00. Next state IF.
- EXE_BR:
  - ALUOp=001, ExtSel=1, PCWre=1. Next state IF.
  - Taken condition: beq taken iff zero=1; bne iff zero=0; bltz iff sign=1 (ALU computes rs-0, rt field = 0).
  - PCSrc=01 if taken, else 00. zero/sign are sampled in this same cycle.
- EXE_MEM: ALUOp=000, ALUSrcB=1, ExtSel=1. Next state MEM.
- MEM:
  - ALU controls held as in EXE_MEM.
  - sw: mWR=1, PCWre=1, PCSrc=00, next state IF.
  - lw: mRD=1, next state WB_LD.
- WB_LD: mRD=1, DBDataSrc=1, RegWre=1, WrRegDSrc=1, RegDst=01, PCWre=1, PCSrc=00. Next state IF.
- Cycle counts:
  - j / jr / jal / NOP: 2 cycles.
  - branch: 3 cycles.
  - ALU and sw: 4 cycles.
  - lw: 5 cycles.
- PCWre is high in exactly one cycle per instruction (never for halt).
- Reset asserted mid-instruction: any write strobes in that cycle are suppressed; IF is entered at the next edge.

Optional Feature:
- Macro: MEM_WAIT_EN.
- When defined, MEM stays in MEM while mem_ready=0. mRD/mWR remain asserted, PCWre=0, and the next state is taken only in a cycle with mem_ready=1.
- When undefined, mem_ready is ignored and MEM always takes one cycle.

Test Plan:
- Reset=1 for 2 edges, then 0 -> state=000, all strobes 0 during reset; IRWre=1 and InsMemRW=1 in the first IF cycle.
- opcode=000000 -> state sequence 000, 001, 110, 111, 000; RegWre=1, RegDst=10 and PCWre=1 only in 111.
- opcode=110001 -> sequence 000, 001, 010, 011, 100, 000; mRD=1 in 011 and 100; RegWre=1, DBDataSrc=1 in 100.
- opcode=110100 with zero=1 -> PCSrc=01 in 101; repeat with zero=0 -> PCSrc=00; opcode=110110 with sign=1 -> PCSrc=01.
- opcode=111010 -> in 001: PCWre=1, PCSrc=11, RegWre=1, RegDst=00, WrRegDSrc=0; opcode=111111 -> PCWre never asserted over 10 cycles.
- With MEM_WAIT_EN and opcode=110000, mem_ready low for 3 cycles -> state stays 011 with mWR=1 and PCWre=0 for 3 cycles; PCWre=1 on the cycle mem_ready=1.

Source files
------------

// File: rtl/mc_control_unit_if.sv
// Control/datapath boundary of the multi-cycle CPU.
// master: the control unit (drives every strobe and select, reads opcode/flags).
// slave:  the datapath side (drives opcode/flags, receives the controls).
interface mc_control_unit_if #(
    parameter int OPW = 6,
    parameter int STW = 3
);
    logic [OPW-1:0] opcode;
    logic           zero;
    logic           sign;
    logic           mem_ready;
    logic           PCWre;
    logic           IRWre;
    logic           InsMemRW;
    logic           ALUSrcA;
    logic           ALUSrcB;
    logic [2:0]     ALUOp;
    logic           ExtSel;
    logic [1:0]     RegDst;
    logic           RegWre;
    logic           WrRegDSrc;
    logic           DBDataSrc;
    logic           mRD;
    logic           mWR;
    logic [1:0]     PCSrc;
    logic [STW-1:0] state;

    modport master (
        input  opcode, zero, sign, mem_ready,
        output PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB, ALUOp, ExtSel,
               RegDst, RegWre, WrRegDSrc, DBDataSrc, mRD, mWR, PCSrc, state
    );

    modport slave (
        output opcode, zero, sign, mem_ready,
        input  PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB, ALUOp, ExtSel,
               RegDst, RegWre, WrRegDSrc, DBDataSrc, mRD, mWR, PCSrc, state
    );
endinterface

// File: rtl/mc_control_unit.sv
// Multi-cycle CPU control FSM: sequences fetch, decode, execute, memory and
// write-back. Controls are decoded from the current state and the opcode/flags.
// Optional macro MEM_WAIT_EN: when defined, the MEM state holds until
// mem_ready=1; when undefined mem_ready is ignored and MEM lasts one cycle.
module mc_control_unit #(
    parameter int OPW = 6,
    parameter int STW = 3
) (
    input  logic               CLK,
    input  logic               Reset,
    mc_control_unit_if.master  bus
);
    localparam logic [OPW-1:0] OP_ADD  = 6'b000000;
    localparam logic [OPW-1:0] OP_SUB  = 6'b000001;
    localparam logic [OPW-1:0] OP_ADDI = 6'b000010;
    localparam logic [OPW-1:0] OP_OR   = 6'b010000;
    localparam logic [OPW-1:0] OP_AND  = 6'b010001;
    localparam logic [OPW-1:0] OP_ORI  = 6'b010010;
    localparam logic [OPW-1:0] OP_SLL  = 6'b011000;
    localparam logic [OPW-1:0] OP_SLT  = 6'b100110;
    localparam logic [OPW-1:0] OP_SLTI = 6'b100111;
    localparam logic [OPW-1:0] OP_SW   = 6'b110000;
    localparam logic [OPW-1:0] OP_LW   = 6'b110001;
    localparam logic [OPW-1:0] OP_BEQ  = 6'b110100;
    localparam logic [OPW-1:0] OP_BNE  = 6'b110101;
    localparam logic [OPW-1:0] OP_BLTZ = 6'b110110;
    localparam logic [OPW-1:0] OP_J    = 6'b111000;
    localparam logic [OPW-1:0] OP_JR   = 6'b111001;
    localparam logic [OPW-1:0] OP_JAL  = 6'b111010;

    typedef enum logic [STW-1:0] {
        S_IF      = 3'b000,
        S_ID      = 3'b001,
        S_EXE_MEM = 3'b010,
        S_MEM     = 3'b011,
        S_WB_LD   = 3'b100,
        S_EXE_BR  = 3'b101,
        S_EXE_ALU = 3'b110,
        S_WB_ALU  = 3'b111
    } state_t;

    state_t state_r;
    logic   mem_go_s;

    // Register-register and register-immediate ALU instructions.
    function automatic logic is_alu(input logic [OPW-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_ADDI, OP_OR, OP_AND,
            OP_ORI, OP_SLL, OP_SLT, OP_SLTI: is_alu = 1'b1;
            default:                         is_alu = 1'b0;
        endcase
    endfunction

    // Immediate-form ALU instructions write rt and take operand B from the immediate.
    function automatic logic is_imm(input logic [OPW-1:0] op);
        case (op)
            OP_ADDI, OP_ORI, OP_SLTI: is_imm = 1'b1;
            default:                  is_imm = 1'b0;
        endcase
    endfunction

    // ALU operation code; immediate forms share the operation of their R-form.
    function automatic logic [2:0] alu_op(input logic [OPW-1:0] op);
        case (op)
            OP_SUB:          alu_op = 3'b001;
            OP_SLL:          alu_op = 3'b010;
            OP_OR, OP_ORI:   alu_op = 3'b011;
            OP_AND:          alu_op = 3'b100;
            OP_SLT, OP_SLTI: alu_op = 3'b110;
            default:         alu_op = 3'b000;
        endcase
    endfunction

`ifdef MEM_WAIT_EN
    assign mem_go_s = bus.mem_ready;
`else
    assign mem_go_s = 1'b1;
`endif

    assign bus.state = state_r;

    // State register: one instruction phase per cycle, IF after every retire.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_r <= S_IF;
        end else begin
            case (state_r)
                S_IF: state_r <= S_ID;
                S_ID: begin
                    if (bus.opcode == OP_BEQ || bus.opcode == OP_BNE || bus.opcode == OP_BLTZ) begin
                        state_r <= S_EXE_BR;
                    end else if (bus.opcode == OP_LW || bus.opcode == OP_SW) begin
                        state_r <= S_EXE_MEM;
                    end else if (is_alu(bus.opcode)) begin
                        state_r <= S_EXE_ALU;
                    end else begin
                        state_r <= S_IF;
                    end
                end
                S_EXE_ALU: state_r <= S_WB_ALU;
                S_WB_ALU:  state_r <= S_IF;
                S_EXE_BR:  state_r <= S_IF;
                S_EXE_MEM: state_r <= S_MEM;
                S_MEM: begin
                    if (!mem_go_s) begin
                        state_r <= S_MEM;
                    end else if (bus.opcode == OP_LW) begin
                        state_r <= S_WB_LD;
                    end else begin
                        state_r <= S_IF;
                    end
                end
                S_WB_LD:   state_r <= S_IF;
                default:   state_r <= S_IF;
            endcase
        end
    end

    // Control decode from state, opcode and flags; everything forced low in reset.
    always_comb begin
        bus.PCWre     = 1'b0;
        bus.IRWre     = 1'b0;
        bus.InsMemRW  = 1'b0;
        bus.ALUSrcA   = 1'b0;
        bus.ALUSrcB   = 1'b0;
        bus.ALUOp     = 3'b000;
        bus.ExtSel    = 1'b0;
        bus.RegDst    = 2'b00;
        bus.RegWre    = 1'b0;
        bus.WrRegDSrc = 1'b0;
        bus.DBDataSrc = 1'b0;
        bus.mRD       = 1'b0;
        bus.mWR       = 1'b0;
        bus.PCSrc     = 2'b00;
        if (Reset) begin
            bus.PCWre = 1'b0;
        end else begin
            case (state_r)
                S_IF: begin
                    bus.IRWre    = 1'b1;
                    bus.InsMemRW = 1'b1;
                end
                S_ID: begin
                    case (bus.opcode)
                        OP_J: begin
                            bus.PCWre = 1'b1;
                            bus.PCSrc = 2'b11;
                        end
                        OP_JR: begin
                            bus.PCWre = 1'b1;
                            bus.PCSrc = 2'b10;
                        end
                        OP_JAL: begin
                            bus.PCWre  = 1'b1;
                            bus.PCSrc  = 2'b11;
                            bus.RegWre = 1'b1;
                        end
                        6'b111111, OP_BEQ, OP_BNE, OP_BLTZ, OP_LW, OP_SW: bus.PCWre = 1'b0;
                        default: bus.PCWre = !is_alu(bus.opcode);
                    endcase
                end
                S_EXE_ALU, S_WB_ALU: begin
                    bus.ALUOp   = alu_op(bus.opcode);
                    bus.ALUSrcB = is_imm(bus.opcode);
                    bus.ALUSrcA = (bus.opcode == OP_SLL);
                    bus.ExtSel  = (bus.opcode != OP_ORI);
                    if (state_r == S_WB_ALU) begin
                        bus.RegWre    = 1'b1;
                        bus.WrRegDSrc = 1'b1;
                        bus.RegDst    = is_imm(bus.opcode) ? 2'b01 : 2'b10;
                        bus.PCWre     = 1'b1;
                    end else begin
                        bus.RegWre = 1'b0;
                    end
                end
                S_EXE_BR: begin
                    bus.ALUOp  = 3'b001;
                    bus.ExtSel = 1'b1;
                    bus.PCWre  = 1'b1;
                    case (bus.opcode)
                        OP_BEQ:  bus.PCSrc = bus.zero ? 2'b01 : 2'b00;
                        OP_BNE:  bus.PCSrc = bus.zero ? 2'b00 : 2'b01;
                        OP_BLTZ: bus.PCSrc = bus.sign ? 2'b01 : 2'b00;
                        default: bus.PCSrc = 2'b00;
                    endcase
                end
                S_EXE_MEM, S_MEM: begin
                    bus.ALUSrcB = 1'b1;
                    bus.ExtSel  = 1'b1;
                    if (state_r == S_MEM) begin
                        if (bus.opcode == OP_SW) begin
                            bus.mWR   = 1'b1;
                            bus.PCWre = mem_go_s;
                        end else begin
                            bus.mRD = 1'b1;
                        end
                    end else begin
                        bus.mRD = 1'b0;
                    end
                end
                S_WB_LD: begin
                    bus.mRD       = 1'b1;
                    bus.DBDataSrc = 1'b1;
                    bus.RegWre    = 1'b1;
                    bus.WrRegDSrc = 1'b1;
                    bus.RegDst    = 2'b01;
                    bus.PCWre     = 1'b1;
                end
                default: bus.PCWre = 1'b0;
            endcase
        end
    end
endmodule
